graph_trace_gen: RTL and testbench
==================================

// Module: graph_trace_gen
// PURPOSE
//  Per-pixel trace generator for the sensor graph panel. Holds a rolling history of
//  the five sensor channels (bit0 HUM, bit1 TEMP, bit2 MAGX, bit3 MAGY, bit4 MAGZ),
//  each pre-scaled upstream to the graph height. For each scanned pixel it emits the
//  5-bit px_code consumed by the RGB colour mixer. Newest sample is drawn at the
//  right edge and the trace scrolls left.
// PARAMETERS
//  GRAPH_W  128  columns = samples kept per channel (power of two)
//  X_BITS   7    log2(GRAPH_W)
//  Y_BITS   7    sample/row width; graph height GRAPH_H = 2**Y_BITS
// PORTS
//  clk            in   1        system clock
//  rst_n          in   1        asynchronous active-low reset
//  sample_valid   in   1        1-cycle strobe: store one sample per channel
//  sample_data    in   5*Y_BITS channel k in bits [k*Y_BITS +: Y_BITS]
//  freeze         in   1        1 = ignore sample_valid (hold display)
//  clear          in   1        synchronous: empty history
//  px_in_graph    in   1        current pixel lies inside graph area
//  px_x           in   X_BITS   column within graph, 0 = left
//  px_y           in   Y_BITS   row within graph, 0 = top
//  px_code        out  5        per-channel "pixel on trace" bits
//  px_code_valid  out  1        px_code corresponds to pixel presented 2 cycles earlier
// BEHAVIOUR
//  Reset (async, rst_n=0): wr_ptr=0, count=0, px_code=0, px_code_valid=0, pipeline
//   regs cleared. Sample storage is not reset (masked by count=0).
//  Write: sample_valid & ~freeze & ~clear -> buf[k][wr_ptr] <= channel k,
//   wr_ptr <= wr_ptr+1 (wraps mod GRAPH_W), count <= min(count+1, GRAPH_W).
//   count saturates at GRAPH_W; thereafter the oldest sample is overwritten.
//  clear: wr_ptr<=0, count<=0; has priority over a same-cycle sample_valid.
//  Column mapping: age a = GRAPH_W-1-px_x; column present iff a < count;
//   sample s0 = buf[(wr_ptr-1-a) mod GRAPH_W]; neighbour s1 = buf[(wr_ptr-2-a) mod
//   GRAPH_W], present iff a+1 < count.
//  Row value v = GRAPH_H-1-px_y (bottom row = value 0).
//  Bit k set iff px_in_graph & column present &
//   (neighbour present ? min(s0,s1) <= v <= max(s0,s1) : v == s0).
//   Vertical fill between adjacent samples gives a continuous line.
//  Pipeline: stage1 registers px_in_graph, v, s0, s1, presence flags for all
//   channels; stage2 registers compare result into px_code. Latency exactly 2
//   cycles; px_code_valid = px_in_graph delayed 2; px_code=0 when invalid.
//  Throughput: one pixel per clock, no stalls.
//  Same-cycle write and pixel read: stage1 samples pre-write buffer and wr_ptr/count;
//   the new sample appears from the next pixel onward (single-pixel tearing accepted).
//  Arithmetic: all index math mod GRAPH_W in X_BITS; comparisons unsigned Y_BITS.
//  Reset mid-frame: outputs go 0 immediately; next pixels drawn with empty history.
// TESTING
//  1 Reset, no samples, sweep all pixels -> px_code=0 everywhere, valid tracks
//    px_in_graph with 2-cycle delay.
//  2 One sample, all channels=10 -> only (x=127,y=117) gives px_code=5'h1F; x=126 -> 0.
//  3 Samples HUM 20 then 30 -> at x=127 bit0 set for y=97..107, clear at y=96,108;
//    x=126 only y=107.
//  4 Write 130 samples (value=index mod 128) -> count=128, wr_ptr=2; x=127 shows
//    value 1, x=0 shows value 2 (oldest).
//  5 freeze=1 with sample_valid pulses -> wr_ptr/count unchanged, image unchanged;
//    clear with sample_valid same cycle -> count=0, all px_code=0.
//  6 Assert rst_n=0 mid-sweep with pipeline full -> px_code/valid 0 asynchronously.

Source files
------------

// File: rtl/graph_trace_gen.sv
// Per-pixel trace generator for the sensor graph panel: keeps a rolling history of
// five sensor channels and emits a 5-bit "pixel on trace" code with 2-cycle latency.
module graph_trace_gen #(
  parameter int GRAPH_W = 128,
  parameter int X_BITS  = 7,
  parameter int Y_BITS  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_valid,
  input  logic [5*Y_BITS-1:0]   sample_data,
  input  logic                  freeze,
  input  logic                  clear,
  input  logic                  px_in_graph,
  input  logic [X_BITS-1:0]     px_x,
  input  logic [Y_BITS-1:0]     px_y,
  output logic [4:0]            px_code,
  output logic                  px_code_valid
);

  localparam int N_CH    = 5;
  localparam int GRAPH_H = 2 ** Y_BITS;
  localparam int CNT_W   = X_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(GRAPH_W);

  logic [Y_BITS-1:0] hist_r [N_CH][GRAPH_W];
  logic [X_BITS-1:0] wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              write_en_s;

  logic [X_BITS-1:0] age_s;
  logic [X_BITS-1:0] idx0_s;
  logic [X_BITS-1:0] idx1_s;
  logic              pres0_s;
  logic              pres1_s;
  logic [Y_BITS-1:0] v_s;
  logic [Y_BITS-1:0] s0_s [N_CH];
  logic [Y_BITS-1:0] s1_s [N_CH];

  logic              in_graph_r;
  logic              pres0_r;
  logic              pres1_r;
  logic [Y_BITS-1:0] v_r;
  logic [Y_BITS-1:0] s0_r [N_CH];
  logic [Y_BITS-1:0] s1_r [N_CH];

  logic [Y_BITS-1:0] lo_s [N_CH];
  logic [Y_BITS-1:0] hi_s [N_CH];
  logic [4:0]        code_s;

  assign write_en_s = sample_valid & ~freeze & ~clear;

  // Sample storage; deliberately unreset because count masks stale entries.
  always_ff @(posedge clk) begin
    if (write_en_s) begin
      for (int k = 0; k < N_CH; k++) begin
        hist_r[k][wr_ptr_r] <= sample_data[k*Y_BITS +: Y_BITS];
      end
    end
  end

  // Write pointer and fill level; count saturates once the ring is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (write_en_s) begin
      wr_ptr_r <= wr_ptr_r + X_BITS'(1);
      if (count_r != CNT_FULL) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end else begin
      wr_ptr_r <= wr_ptr_r;
      count_r  <= count_r;
    end
  end

  // Column-to-sample mapping: rightmost column is the newest sample.
  always_comb begin
    age_s   = X_BITS'(GRAPH_W - 1) - px_x;
    idx0_s  = wr_ptr_r - X_BITS'(1) - age_s;
    idx1_s  = idx0_s - X_BITS'(1);
    pres0_s = ({1'b0, age_s} < count_r);
    pres1_s = (({1'b0, age_s} + CNT_W'(1)) < count_r);
    v_s     = Y_BITS'(GRAPH_H - 1) - px_y;
    for (int k = 0; k < N_CH; k++) begin
      s0_s[k] = hist_r[k][idx0_s];
      s1_s[k] = hist_r[k][idx1_s];
    end
  end

  // Stage 1: capture pixel context and both neighbouring samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_graph_r <= 1'b0;
      pres0_r    <= 1'b0;
      pres1_r    <= 1'b0;
      v_r        <= '0;
      for (int k = 0; k < N_CH; k++) begin
        s0_r[k] <= '0;
        s1_r[k] <= '0;
      end
    end else begin
      in_graph_r <= px_in_graph;
      pres0_r    <= pres0_s;
      pres1_r    <= pres1_s;
      v_r        <= v_s;
      for (int k = 0; k < N_CH; k++) begin
        s0_r[k] <= s0_s[k];
        s1_r[k] <= s1_s[k];
      end
    end
  end

  // Trace hit test: vertical span between neighbours, or exact row for a lone sample.
  always_comb begin
    code_s = 5'b0_0000;
    for (int k = 0; k < N_CH; k++) begin
      if (s0_r[k] < s1_r[k]) begin
        lo_s[k] = s0_r[k];
        hi_s[k] = s1_r[k];
      end else begin
        lo_s[k] = s1_r[k];
        hi_s[k] = s0_r[k];
      end
      if (!(in_graph_r && pres0_r)) begin
        code_s[k] = 1'b0;
      end else if (pres1_r) begin
        code_s[k] = (v_r >= lo_s[k]) && (v_r <= hi_s[k]);
      end else begin
        code_s[k] = (v_r == s0_r[k]);
      end
    end
  end

  // Stage 2: registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_code       <= 5'b0_0000;
      px_code_valid <= 1'b0;
    end else begin
      px_code       <= in_graph_r ? code_s : 5'b0_0000;
      px_code_valid <= in_graph_r;
    end
  end

endmodule

// File: tb/tb_graph_trace_gen.sv
// Self-checking bench for graph_trace_gen: queue-based history model compared every
// cycle, plus directed probes with hand-computed pixel codes.
module tb_graph_trace_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [34:0] sample_data = 35'd0;
  logic        freeze = 1'b0;
  logic        clear = 1'b0;
  logic        px_in_graph = 1'b0;
  logic [6:0]  px_x = 7'd0;
  logic [6:0]  px_y = 7'd0;
  logic [4:0]  px_code;
  logic        px_code_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: history as a queue, oldest at front, newest at back.
  logic [34:0] hist[$];
  logic [4:0]  exp_c1 = 5'd0, exp_c2 = 5'd0;
  logic        exp_v1 = 1'b0, exp_v2 = 1'b0;

  graph_trace_gen #(.GRAPH_W(128), .X_BITS(7), .Y_BITS(7)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .freeze(freeze), .clear(clear), .px_in_graph(px_in_graph), .px_x(px_x), .px_y(px_y),
    .px_code(px_code), .px_code_valid(px_code_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] model_code(int x, int y, logic g);
    int n, a, v, s0, s1, lo, hi;
    logic [4:0] r;
    r = 5'd0;
    n = hist.size();
    a = 127 - x;
    v = 127 - y;
    if (g && a < n) begin
      for (int k = 0; k < 5; k++) begin
        s0 = int'((hist[n-1-a] >> (k*7)) & 35'h7F);
        if (a + 1 < n) begin
          s1 = int'((hist[n-2-a] >> (k*7)) & 35'h7F);
          lo = (s0 < s1) ? s0 : s1;
          hi = (s0 < s1) ? s1 : s0;
          r[k] = (v >= lo) && (v <= hi);
        end else begin
          r[k] = (v == s0);
        end
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update on the active edge, tracking async reset.
  initial begin : model_proc
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        hist.delete();
        exp_c1 = 5'd0; exp_c2 = 5'd0;
        exp_v1 = 1'b0; exp_v2 = 1'b0;
      end else begin
        exp_c2 = exp_c1;
        exp_v2 = exp_v1;
        exp_c1 = model_code(int'(px_x), int'(px_y), px_in_graph);
        exp_v1 = px_in_graph;
        if (clear) begin
          hist.delete();
        end else if (sample_valid && !freeze) begin
          hist.push_back(sample_data);
          if (hist.size() > 128) void'(hist.pop_front());
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  initial begin : compare_proc
    forever begin
      @(negedge clk);
      check("px_code", px_code, exp_c2);
      check("px_code_valid", {4'd0, px_code_valid}, {4'd0, exp_v2});
    end
  end

  task automatic drive_px(input int x, input int y, input logic g);
    px_x = 7'(x);
    px_y = 7'(y);
    px_in_graph = g;
    @(negedge clk);
  endtask

  task automatic sweep(input int x0, input int x1);
    for (int x = x0; x <= x1; x++) begin
      for (int y = 0; y < 128; y++) begin
        drive_px(x, y, ((x + y) % 5) != 0);
      end
    end
  endtask

  task automatic probe(input string name, input int x, input int y, input logic [4:0] exp);
    px_x = 7'(x);
    px_y = 7'(y);
    px_in_graph = 1'b1;
    repeat (2) @(negedge clk);
    check(name, px_code, exp);
    check({name, "_valid"}, {4'd0, px_code_valid}, 5'd1);
  endtask

  task automatic write_sample(input logic [34:0] d);
    sample_data = d;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin : stim_proc
    logic [6:0] val;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: empty history, full sweep
    sweep(0, 127);
    probe("empty_127_127", 127, 127, 5'h00);

    // 2: single sample, all channels 10
    write_sample({5{7'd10}});
    probe("one_127_117", 127, 117, 5'h1F);
    probe("one_127_116", 127, 116, 5'h00);
    probe("one_126_117", 126, 117, 5'h00);
    sweep(125, 127);

    // 3: HUM 20 then 30, others 0
    do_clear();
    write_sample({28'd0, 7'd20});
    write_sample({28'd0, 7'd30});
    probe("hum_127_97", 127, 97, 5'h01);
    probe("hum_127_107", 127, 107, 5'h01);
    probe("hum_127_96", 127, 96, 5'h00);
    probe("hum_127_108", 127, 108, 5'h00);
    probe("hum_126_107", 126, 107, 5'h01);
    probe("hum_126_106", 126, 106, 5'h00);
    probe("hum_126_127", 126, 127, 5'h1E);
    sweep(125, 127);

    // 4: 130 samples wrap the ring
    do_clear();
    for (int i = 0; i < 130; i++) begin
      val = 7'(i % 128);
      write_sample({5{val}});
    end
    probe("wrap_127_126", 127, 126, 5'h1F);
    probe("wrap_127_125", 127, 125, 5'h00);
    probe("wrap_0_125", 0, 125, 5'h1F);
    probe("wrap_0_124", 0, 124, 5'h00);
    probe("wrap_0_126", 0, 126, 5'h00);
    sweep(0, 1);
    sweep(126, 127);

    // 5: freeze, then clear beating a same-cycle write
    freeze = 1'b1;
    repeat (3) write_sample({5{7'd50}});
    freeze = 1'b0;
    probe("frz_127_126", 127, 126, 5'h1F);
    probe("frz_127_77", 127, 77, 5'h00);
    sweep(126, 127);
    clear = 1'b1;
    write_sample({5{7'd5}});
    clear = 1'b0;
    probe("clr_127_122", 127, 122, 5'h00);
    probe("clr_127_126", 127, 126, 5'h00);
    sweep(126, 127);

    // 6: async reset with pipeline full
    write_sample({5{7'd60}});
    probe("pre_rst_127_67", 127, 67, 5'h1F);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_px_code", px_code, 5'h00);
    check("rst_valid", {4'd0, px_code_valid}, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    probe("post_rst_127_67", 127, 67, 5'h00);
    sweep(126, 127);

    px_in_graph = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
